vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 clk1_50  input  1  50 MHz system clock; sole clock of the block.
REQ-010 rst  input  1  reset, asynchronous, active-high.
REQ-011 pix_color  input  pkg::color_t  colour for the current (pix_x, pix_y), supplied by the upstream pixel source.
REQ-012 pix_x  output  10  current horizontal counter value.
REQ-013 pix_y  output  10  current vertical counter value.
REQ-014 pix_valid  output  1  high when the current coordinate is visible.
REQ-015 pix_ce  output  1  pixel enable: high on every second clk1_50 cycle (25 MHz pixel rate).
REQ-016 frame_start  output  1  single-clock pulse at the first pixel of each frame.
REQ-017 vga_color  output  pkg::color_t  registered colour to the VGA DAC.
REQ-018 vga_hs  output  1  horizontal sync, active-low.
REQ-019 vga_vs  output  1  vertical sync, active-low.

Function
REQ-020 pix_ce SHALL toggle on every clk1_50 edge; all counters and output registers SHALL update only on edges where pix_ce=1.
REQ-021 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters, 800 default), then wrap to 0.
REQ-022 v_cnt SHALL increment only on the h_cnt wrap, count 0..V_TOTAL-1 (525 default), then wrap to 0; simultaneous h and v wrap SHALL yield h=0, v=0.
REQ-023 pix_x and pix_y SHALL equal h_cnt and v_cnt combinationally.
REQ-024 pix_valid SHALL be (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE), combinationally.
REQ-025 frame_start SHALL equal pix_ce and h_cnt=0 and v_cnt=0 (exactly one clk1_50 cycle per frame).
REQ-026 pix_color SHALL be sampled on the pix_ce edge ending the pixel period in which pix_x/pix_y are presented; the upstream source has one full pixel period (2 clocks) to respond combinationally or from a register updated on the preceding pix_ce.
REQ-027 vga_color SHALL register pix_color when pix_valid=1, otherwise 0, so that blanking is always black.
REQ-028 vga_hs SHALL register low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751 default), high otherwise.
REQ-029 vga_vs SHALL register low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491 default), high otherwise.
REQ-030 vga_color, vga_hs and vga_vs SHALL share the same one-pixel (2-clock) latency relative to the coordinates, so they remain mutually aligned.
REQ-031 H_TOTAL and V_TOTAL SHALL each be <= 1024; larger values are outside the block's range.

Reset
REQ-032 While rst=1: pix_ce=0, h_cnt=0, v_cnt=0, vga_color=0, vga_hs=1, vga_vs=1; frame_start=0 as a consequence of pix_ce=0.
REQ-033 Reset assertion mid-frame SHALL force these values immediately, without waiting for a clock edge.
REQ-034 After release, the first clk1_50 edge SHALL set pix_ce=1 with h=0 and v=0, so frame_start pulses on the second cycle after release.

Verification
REQ-035 Release reset -> pix_ce alternates 1,0,1..., frame_start pulses once, then recurs every 840000 clocks.
REQ-036 Free run -> vga_hs low for exactly 192 consecutive clocks, period 1600 clocks; first falling edge 2 clocks after h_cnt reaches 656.
REQ-037 Free run -> vga_vs low for exactly 3200 clocks per frame, beginning at the pixel after v=490, h=0.
REQ-038 pix_color=12'hFFF constant -> vga_color nonzero for exactly 640 pixels per line on lines 0..479, and 0 on lines 480..524.
REQ-039 pix_color driven from {pix_y[3:0], pix_x[7:0]} -> each vga_color equals the value for the coordinate presented one pixel earlier, including across h and v wrap.
REQ-040 Assert rst at h=300, v=200 mid-clock -> vga_hs=1, vga_vs=1, vga_color=0 without a clock edge; after release, counting restarts at (0,0).

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator: 25 MHz pixel enable derived from a 50 MHz clock,
// h/v counters, active-low syncs and a blanking-gated colour register.
package pkg;
    typedef logic [11:0] color_t;
endpackage

module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk1_50,
    input  logic        rst,
    input  pkg::color_t pix_color,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_valid,
    output logic        pix_ce,
    output logic        frame_start,
    output pkg::color_t vga_color,
    output logic        vga_hs,
    output logic        vga_vs
);

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_last;
    logic       v_last;
    logic       h_in_sync;
    logic       v_in_sync;

    // Compares are done in int so a 1024 total cannot alias in 10 bits.
    always_comb begin
        h_last    = (int'(h_cnt) == H_TOTAL - 1);
        v_last    = (int'(v_cnt) == V_TOTAL - 1);
        h_in_sync = (int'(h_cnt) >= H_SYNC_START) && (int'(h_cnt) < H_SYNC_END);
        v_in_sync = (int'(v_cnt) >= V_SYNC_START) && (int'(v_cnt) < V_SYNC_END);
    end

    assign pix_x       = h_cnt;
    assign pix_y       = v_cnt;
    assign pix_valid   = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign frame_start = pix_ce && (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge clk1_50 or posedge rst) begin
        if (rst) begin
            pix_ce <= 1'b0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else begin
            pix_ce <= ~pix_ce;
            if (pix_ce) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
            end
        end
    end

    // Outputs sample the coordinate of the pixel period that is just ending,
    // so colour and both syncs carry the same one-pixel latency.
    always_ff @(posedge clk1_50 or posedge rst) begin
        if (rst) begin
            vga_color <= '0;
            vga_hs    <= 1'b1;
            vga_vs    <= 1'b1;
        end else if (pix_ce) begin
            vga_color <= pix_valid ? pix_color : '0;
            vga_hs    <= ~h_in_sync;
            vga_vs    <= ~v_in_sync;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: a reduced-geometry instance checked cycle by cycle against a
// position model, plus a default-geometry instance for line-level sync timing.
module tb_vga_timing;

    logic        clk1_50;
    logic        rst;
    pkg::color_t s_color_in;
    pkg::color_t d_color_in;

    logic [9:0]  s_x, s_y, d_x, d_y;
    logic        s_valid, s_ce, s_fs, s_hs, s_vs;
    logic        d_valid, d_ce, d_fs, d_hs, d_vs;
    pkg::color_t s_color, d_color;

    int checks = 0;
    int errors = 0;

    // Small geometry: 16 x 8 total, hsync h=10..12, vsync v=5..6.
    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .clk1_50(clk1_50), .rst(rst), .pix_color(s_color_in),
        .pix_x(s_x), .pix_y(s_y), .pix_valid(s_valid), .pix_ce(s_ce),
        .frame_start(s_fs), .vga_color(s_color), .vga_hs(s_hs), .vga_vs(s_vs)
    );

    vga_timing u_dflt (
        .clk1_50(clk1_50), .rst(rst), .pix_color(d_color_in),
        .pix_x(d_x), .pix_y(d_y), .pix_valid(d_valid), .pix_ce(d_ce),
        .frame_start(d_fs), .vga_color(d_color), .vga_hs(d_hs), .vga_vs(d_vs)
    );

    assign s_color_in = {s_y[3:0], s_x[7:0]};
    assign d_color_in = 12'hFFF;

    initial clk1_50 = 1'b0;
    always #10 clk1_50 = ~clk1_50;

    typedef struct {
        logic        ce;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        valid;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] color;
    } exp_t;

    // k = number of clk1_50 rising edges since reset release.
    function automatic exp_t model(input int k, input int ha, input int hf, input int hsw,
                                   input int hb, input int va, input int vf, input int vsw,
                                   input int vb, input bit const_col);
        exp_t e;
        int ht = ha + hf + hsw + hb;
        int vt = va + vf + vsw + vb;
        int p  = k / 2;
        int h  = p % ht;
        int v  = (p / ht) % vt;
        int ph, pv;
        e.ce    = (k % 2) == 1;
        e.x     = 10'(h);
        e.y     = 10'(v);
        e.valid = (h < ha) && (v < va);
        e.fs    = e.ce && (h == 0) && (v == 0);
        if (p == 0) begin
            e.hs    = 1'b1;
            e.vs    = 1'b1;
            e.color = 12'h000;
        end else begin
            ph      = (p - 1) % ht;
            pv      = ((p - 1) / ht) % vt;
            e.hs    = !((ph >= ha + hf) && (ph < ha + hf + hsw));
            e.vs    = !((pv >= va + vf) && (pv < va + vf + vsw));
            if ((ph < ha) && (pv < va))
                e.color = const_col ? 12'hFFF : 12'((pv % 16) * 256 + (ph % 256));
            else
                e.color = 12'h000;
        end
        return e;
    endfunction

    function automatic exp_t model_small(input int k);
        return model(k, 8, 2, 3, 3, 4, 1, 2, 1, 1'b0);
    endfunction

    function automatic exp_t model_dflt(input int k);
        return model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input int k);
        exp_t es = model_small(k);
        exp_t ed = model_dflt(k);
        chk("s_ce",    32'(s_ce),    32'(es.ce));
        chk("s_x",     32'(s_x),     32'(es.x));
        chk("s_y",     32'(s_y),     32'(es.y));
        chk("s_valid", 32'(s_valid), 32'(es.valid));
        chk("s_fs",    32'(s_fs),    32'(es.fs));
        chk("s_hs",    32'(s_hs),    32'(es.hs));
        chk("s_vs",    32'(s_vs),    32'(es.vs));
        chk("s_color", 32'(s_color), 32'(es.color));
        chk("d_ce",    32'(d_ce),    32'(ed.ce));
        chk("d_x",     32'(d_x),     32'(ed.x));
        chk("d_y",     32'(d_y),     32'(ed.y));
        chk("d_valid", 32'(d_valid), 32'(ed.valid));
        chk("d_fs",    32'(d_fs),    32'(ed.fs));
        chk("d_hs",    32'(d_hs),    32'(ed.hs));
        chk("d_vs",    32'(d_vs),    32'(ed.vs));
        chk("d_color", 32'(d_color), 32'(ed.color));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ce"},    32'(s_ce),    32'd0);
        chk({tag, "_x"},     32'(s_x),     32'd0);
        chk({tag, "_y"},     32'(s_y),     32'd0);
        chk({tag, "_fs"},    32'(s_fs),    32'd0);
        chk({tag, "_hs"},    32'(s_hs),    32'd1);
        chk({tag, "_vs"},    32'(s_vs),    32'd1);
        chk({tag, "_color"}, 32'(s_color), 32'd0);
        chk({tag, "_dhs"},   32'(d_hs),    32'd1);
        chk({tag, "_dcolor"},32'(d_color), 32'd0);
    endtask

    initial begin
        int k;
        int fall1, fall2, first_run, run;
        logic prev_hs;
        bit found;
        exp_t e;

        // Reset held across several edges.
        rst = 1'b1;
        repeat (3) @(negedge clk1_50);
        check_reset_state("rst_hold");

        // Release and free-run: every cycle against the model.
        rst = 1'b0;
        #1;
        k = 0;
        check_all(k);
        fall1 = -1; fall2 = -1; first_run = -1; run = 0;
        prev_hs = d_hs;
        for (int i = 1; i <= 3400; i++) begin
            @(negedge clk1_50);
            k = i;
            check_all(k);
            if (prev_hs && !d_hs) begin
                if (fall1 < 0) fall1 = k;
                else if (fall2 < 0) fall2 = k;
            end
            if (!d_hs) run++;
            else begin
                if (run > 0 && first_run < 0) first_run = run;
                run = 0;
            end
            prev_hs = d_hs;
        end
        chk("d_hs_first_fall", 32'(fall1), 32'd1314);
        chk("d_hs_period",     32'(fall2 - fall1), 32'd1600);
        chk("d_hs_low_len",    32'(first_run), 32'd192);

        // Async reset while both syncs are low.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk1_50);
            k++;
            e = model_small(k);
            if (!e.hs && !e.vs) found = 1'b1;
        end
        chk("seek_sync_low", 32'(found), 32'd1);
        chk("pre_rst_hs", 32'(s_hs), 32'd0);
        chk("pre_rst_vs", 32'(s_vs), 32'd0);
        #3 rst = 1'b1;
        #1;
        check_reset_state("async1");
        repeat (2) @(negedge clk1_50);
        check_reset_state("async1_hold");

        // Restart from (0,0) after release.
        rst = 1'b0;
        #1;
        k = 0;
        check_all(k);
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk1_50);
            k = i;
            check_all(k);
        end

        // Async reset while colour output is nonzero.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk1_50);
            k++;
            e = model_small(k);
            if (e.color != 12'h000) found = 1'b1;
        end
        chk("seek_color", 32'(found), 32'd1);
        chk("pre_rst_color_nz", 32'(s_color != 12'h000), 32'd1);
        #3 rst = 1'b1;
        #1;
        check_reset_state("async2");
        @(negedge clk1_50);
        rst = 1'b0;
        #1;
        k = 0;
        check_all(k);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk1_50);
            k = i;
            check_all(k);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
